// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: register addresses, register bit
// positions and the TX/RX state encodings.
package uart_pkg;

   localparam logic [4:0] ADDR_CTRL    = 5'd0;
   localparam logic [4:0] ADDR_CMD     = 5'd1;
   localparam logic [4:0] ADDR_TX_DATA = 5'd2;
   localparam logic [4:0] ADDR_STATUS  = 5'd3;
   localparam logic [4:0] ADDR_RX_DATA = 5'd4;

   localparam int CTRL_TX_EN     = 0;
   localparam int CTRL_RX_EN     = 1;
   localparam int CTRL_PARITY_EN = 2;

   localparam int ST_TX_BUSY    = 0;
   localparam int ST_RX_VALID   = 1;
   localparam int ST_FRAME_ERR  = 2;
   localparam int ST_PARITY_ERR = 3;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: full_tick on the last cycle of each bit, half_tick mid-bit.
// Zero latency from clr; the divisor is re-latched only at bit boundaries.
module uart_bit_timer (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        clr,
   input  logic [15:0] div,
   output logic        full_tick,
   output logic        half_tick
);

   logic [15:0] cnt;
   logic [15:0] div_q;
   logic [15:0] div_eff;
   logic [15:0] half;

   assign div_eff   = (div == 16'd0) ? 16'd1 : div;
   assign half      = div_q >> 1;
   assign full_tick = (cnt == div_q - 16'd1);
   assign half_tick = (half == 16'd0) ? (cnt == 16'd0) : (cnt == half - 16'd1);

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         cnt   <= '0;
         div_q <= 16'd1;
      end else if (clr || full_tick) begin
         cnt   <= '0;
         div_q <= div_eff;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/uart_core_top.sv
// 8N1 UART with a register-mapped config port; tx_o starts one cycle after CMD,
// commands while busy are dropped. Even parity is built when UART_PARITY_EN is defined.
module uart_core_top
   import uart_pkg::*;
#(
   parameter int DIV_RESET = 10416,
   parameter int DATA_W    = 8
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        rx_i,
   output logic        tx_o,
   output logic        rx_data_valid_o,
   output logic [7:0]  rx_data_o,
   input  logic [7:0]  tx_data_i,
   input  logic        cfg_we,
   input  logic        cfg_cs,
   input  logic [31:0] cfg_data_i,
   output logic [31:0] cfg_data_o,
   input  logic [4:0]  cfg_addr_i
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   logic [15:0] div_q;
   logic        tx_en, rx_en, par_en;
   logic [7:0]  tx_data_q;
   logic        rx_valid_q, frame_err_q, parity_err_q;
   logic        wr, rd, st_wr, tx_busy;
   logic        unused_ok;

   tx_state_t   tx_state, tx_next;
   logic [7:0]  tx_sh, tx_sh_next, tx_byte;
   logic [2:0]  tx_cnt, tx_cnt_next;
   logic        tx_par, tx_par_next, tx_line_next;
   logic        tx_go, tx_full, tx_half_unused;

   rx_state_t   rx_state, rx_next;
   logic [7:0]  rx_sh, rx_sh_next;
   logic [2:0]  rx_cnt, rx_cnt_next;
   logic        rx_s1, rx_s2, rx_prev;
   logic        rx_full, rx_half, rx_tmr_clr;
   logic        rx_ok, frame_set, par_set, par_bad, par_bad_next;

   assign wr        = cfg_cs && cfg_we;
   assign rd        = cfg_cs && !cfg_we;
   assign st_wr     = wr && (cfg_addr_i == ADDR_STATUS);
   assign tx_busy   = (tx_state != TX_IDLE);
   assign unused_ok = ^cfg_data_i[15:3];

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         div_q        <= 16'(DIV_RESET);
         tx_en        <= 1'b0;
         rx_en        <= 1'b0;
         tx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         if (wr && cfg_addr_i == ADDR_CTRL) begin
            div_q <= cfg_data_i[31:16];
            rx_en <= cfg_data_i[CTRL_RX_EN];
            tx_en <= cfg_data_i[CTRL_TX_EN];
         end
         if (wr && cfg_addr_i == ADDR_TX_DATA)
            tx_data_q <= cfg_data_i[7:0];
         // A fresh byte wins over a simultaneous clear so it is never lost.
         if (rx_ok)
            rx_valid_q <= 1'b1;
         else if ((st_wr && cfg_data_i[ST_RX_VALID]) || (rd && cfg_addr_i == ADDR_RX_DATA))
            rx_valid_q <= 1'b0;
         if (frame_set)
            frame_err_q <= 1'b1;
         else if (st_wr && cfg_data_i[ST_FRAME_ERR])
            frame_err_q <= 1'b0;
         if (par_set)
            parity_err_q <= 1'b1;
         else if (st_wr && cfg_data_i[ST_PARITY_ERR])
            parity_err_q <= 1'b0;
      end
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i)
         par_en <= 1'b0;
      else if (wr && cfg_addr_i == ADDR_CTRL)
         par_en <= cfg_data_i[CTRL_PARITY_EN];
   end
`else
   assign par_en = 1'b0;
`endif

   always_comb begin
      cfg_data_o = '0;
      if (rd) begin
         case (cfg_addr_i)
            ADDR_CTRL: begin
               cfg_data_o[31:16]          = div_q;
               cfg_data_o[CTRL_PARITY_EN] = par_en;
               cfg_data_o[CTRL_RX_EN]     = rx_en;
               cfg_data_o[CTRL_TX_EN]     = tx_en;
            end
            ADDR_TX_DATA: cfg_data_o[7:0] = tx_data_q;
            ADDR_STATUS: begin
               cfg_data_o[ST_TX_BUSY]    = tx_busy;
               cfg_data_o[ST_RX_VALID]   = rx_valid_q;
               cfg_data_o[ST_FRAME_ERR]  = frame_err_q;
               cfg_data_o[ST_PARITY_ERR] = parity_err_q;
            end
            ADDR_RX_DATA: cfg_data_o[7:0] = rx_data_o;
            default: cfg_data_o = '0;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   assign tx_go   = wr && (cfg_addr_i == ADDR_CMD) && (cfg_data_i[0] || cfg_data_i[1])
                    && tx_en && (tx_state == TX_IDLE);
   assign tx_byte = cfg_data_i[0] ? tx_data_q : tx_data_i;

   uart_bit_timer u_tx_tmr (
      .clk       (clk),
      .rst_i     (rst_i),
      .clr       (tx_state == TX_IDLE),
      .div       (div_q),
      .full_tick (tx_full),
      .half_tick (tx_half_unused)
   );

   always_comb begin
      tx_next      = tx_state;
      tx_sh_next   = tx_sh;
      tx_cnt_next  = tx_cnt;
      tx_par_next  = tx_par;
      tx_line_next = tx_o;
      case (tx_state)
         TX_IDLE: begin
            tx_line_next = 1'b1;
            if (tx_go) begin
               tx_next      = TX_START;
               tx_sh_next   = tx_byte;
               tx_par_next  = ^tx_byte;
               tx_line_next = 1'b0;
            end
         end
         TX_START: if (tx_full) begin
            tx_next      = TX_DATA;
            tx_cnt_next  = '0;
            tx_line_next = tx_sh[0];
         end
         TX_DATA: if (tx_full) begin
            if (tx_cnt == LAST_BIT) begin
               tx_next      = par_en ? TX_PARITY : TX_STOP;
               tx_line_next = par_en ? tx_par : 1'b1;
            end else begin
               tx_sh_next   = tx_sh >> 1;
               tx_cnt_next  = tx_cnt + 3'd1;
               tx_line_next = tx_sh[1];
            end
         end
         TX_PARITY: if (tx_full) begin
            tx_next      = TX_STOP;
            tx_line_next = 1'b1;
         end
         TX_STOP: if (tx_full) begin
            tx_next      = TX_IDLE;
            tx_line_next = 1'b1;
         end
         default: begin
            tx_next      = TX_IDLE;
            tx_line_next = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         tx_state <= TX_IDLE;
         tx_sh    <= '0;
         tx_cnt   <= '0;
         tx_par   <= 1'b0;
         tx_o     <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_sh    <= tx_sh_next;
         tx_cnt   <= tx_cnt_next;
         tx_par   <= tx_par_next;
         tx_o     <= tx_line_next;
      end
   end

   // ---------------- receiver ----------------
   uart_bit_timer u_rx_tmr (
      .clk       (clk),
      .rst_i     (rst_i),
      .clr       (rx_tmr_clr),
      .div       (div_q),
      .full_tick (rx_full),
      .half_tick (rx_half)
   );

   always_comb begin
      rx_next      = rx_state;
      rx_sh_next   = rx_sh;
      rx_cnt_next  = rx_cnt;
      par_bad_next = par_bad;
      rx_tmr_clr   = (rx_state == RX_IDLE) || (rx_state == RX_WAIT_HIGH);
      rx_ok        = 1'b0;
      frame_set    = 1'b0;
      par_set      = 1'b0;
      case (rx_state)
         RX_IDLE: if (rx_prev && !rx_s2) rx_next = RX_START;
         RX_START: if (rx_half) begin
            // Restarting the timer here puts every later full_tick at mid-bit.
            rx_next      = rx_s2 ? RX_IDLE : RX_DATA;
            rx_tmr_clr   = 1'b1;
            rx_cnt_next  = '0;
            par_bad_next = 1'b0;
         end
         RX_DATA: if (rx_full) begin
            rx_sh_next  = {rx_s2, rx_sh[7:1]};
            rx_cnt_next = rx_cnt + 3'd1;
            if (rx_cnt == LAST_BIT)
               rx_next = par_en ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: if (rx_full) begin
            rx_next = RX_STOP;
            if (rx_s2 != ^rx_sh) begin
               par_set      = 1'b1;
               par_bad_next = 1'b1;
            end
         end
         RX_STOP: if (rx_full) begin
            if (rx_s2) begin
               rx_next = RX_IDLE;
               rx_ok   = !par_bad;
            end else begin
               rx_next   = RX_WAIT_HIGH;
               frame_set = 1'b1;
            end
         end
         RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
         default: rx_next = RX_IDLE;
      endcase
      if (!rx_en) begin
         rx_next   = RX_IDLE;
         rx_ok     = 1'b0;
         frame_set = 1'b0;
         par_set   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         rx_s1           <= 1'b1;
         rx_s2           <= 1'b1;
         rx_prev         <= 1'b1;
         rx_state        <= RX_IDLE;
         rx_sh           <= '0;
         rx_cnt          <= '0;
         par_bad         <= 1'b0;
         rx_data_o       <= '0;
         rx_data_valid_o <= 1'b0;
      end else begin
         rx_s1           <= rx_i;
         rx_s2           <= rx_s1;
         rx_prev         <= rx_s2;
         rx_state        <= rx_next;
         rx_sh           <= rx_sh_next;
         rx_cnt          <= rx_cnt_next;
         par_bad         <= par_bad_next;
         rx_data_valid_o <= rx_ok;
         if (rx_ok)
            rx_data_o <= rx_sh;
      end
   end

endmodule

// File: tb/tb_uart_core_top.sv
// Directed bench for uart_core_top: register access, loopback frames, RX error
// cases and reset mid-frame, with hand-computed expectations.
module tb_uart_core_top;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        rx_i;
   logic        tx_o;
   logic        rx_data_valid_o;
   logic [7:0]  rx_data_o;
   logic [7:0]  tx_data_i;
   logic        cfg_we;
   logic        cfg_cs;
   logic [31:0] cfg_data_i;
   logic [31:0] cfg_data_o;
   logic [4:0]  cfg_addr_i;

   logic        loop_en;
   logic        rx_drv;
   int          vectors = 0;
   int          errors  = 0;
   int          strobe_cnt = 0;
   logic [7:0]  last_rx = 8'h00;
   logic [31:0] rd_val;

   assign rx_i = loop_en ? tx_o : rx_drv;

   always #5 clk = ~clk;

   uart_core_top dut (
      .clk             (clk),
      .rst_i           (rst_i),
      .rx_i            (rx_i),
      .tx_o            (tx_o),
      .rx_data_valid_o (rx_data_valid_o),
      .rx_data_o       (rx_data_o),
      .tx_data_i       (tx_data_i),
      .cfg_we          (cfg_we),
      .cfg_cs          (cfg_cs),
      .cfg_data_i      (cfg_data_i),
      .cfg_data_o      (cfg_data_o),
      .cfg_addr_i      (cfg_addr_i)
   );

   always @(negedge clk) begin
      if (rx_data_valid_o === 1'b1) begin
         strobe_cnt = strobe_cnt + 1;
         last_rx    = rx_data_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr_i = a; cfg_data_i = d;
      @(negedge clk);
      cfg_cs = 1'b0; cfg_we = 1'b0; cfg_data_i = '0;
   endtask

   task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      cfg_cs = 1'b1; cfg_we = 1'b0; cfg_addr_i = a;
      #1 d = cfg_data_o;
      @(posedge clk);
      #1 cfg_cs = 1'b0;
   endtask

   task automatic check_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] v;
      cfg_read(a, v);
      check(tag, v, exp);
   endtask

   // Samples tx_o once per bit; starts 'off' negedges after the caller's current one.
   task automatic tx_frame_check(input string tag, input logic [9:0] fr, input int per, input int off);
      repeat (off) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("%s_bit%0d", tag, k), {31'b0, tx_o}, {31'b0, fr[k]});
         repeat (per) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit, input logic stop_bit);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (10) @(negedge clk);
      end
      if (par_on) begin
         rx_drv = par_bit;
         repeat (10) @(negedge clk);
      end
      rx_drv = stop_bit;
      repeat (10) @(negedge clk);
      rx_drv = 1'b1;
   endtask

   initial begin
      rst_i = 1'b0; loop_en = 1'b0; rx_drv = 1'b1; tx_data_i = 8'h00;
      cfg_we = 1'b0; cfg_cs = 1'b0; cfg_data_i = '0; cfg_addr_i = '0;
      repeat (3) @(negedge clk);
      rst_i = 1'b1;
      wait_cyc(1);

      // Reset state
      check("rst_tx_o", {31'b0, tx_o}, 32'd1);
      check("rst_valid", {31'b0, rx_data_valid_o}, 32'd0);
      check("rst_rx_data", {24'b0, rx_data_o}, 32'd0);
      check_read("rst_ctrl", 5'd0, 32'h28B0_0000);
      check_read("rst_status", 5'd3, 32'h0);

      // Register access
      cfg_write(5'd0, 32'h000A_0003);
      check_read("ctrl_rb", 5'd0, 32'h000A_0003);
      check_read("unmapped_rd", 5'd9, 32'h0);
      cfg_write(5'd2, 32'h0000_0055);
      check_read("txdata_rb", 5'd2, 32'h55);

      // Loopback 0x55 at DIV=10
      loop_en = 1'b1;
      cfg_write(5'd1, 32'h1);
      check("start_1cyc", {31'b0, tx_o}, 32'd0);
      tx_frame_check("f55", {1'b1, 8'h55, 1'b0}, 10, 5);
      wait_cyc(10);
      check_read("status_after_55", 5'd3, 32'h2);
      check("strobes_55", strobe_cnt, 32'd1);
      check("last_rx_55", {24'b0, last_rx}, 32'h55);
      check_read("rxdata_55", 5'd4, 32'h55);
      check_read("rx_valid_cleared", 5'd3, 32'h0);

      // Command while busy is dropped; then CMD bit1 sends tx_data_i
      cfg_write(5'd1, 32'h1);
      wait_cyc(30);
      tx_data_i = 8'hA3;
      cfg_write(5'd1, 32'h2);
      check_read("busy_mid", 5'd3, 32'h1);
      wait_cyc(90);
      check("strobes_busy", strobe_cnt, 32'd2);
      check("last_rx_busy", {24'b0, last_rx}, 32'h55);
      cfg_write(5'd1, 32'h2);
      wait_cyc(110);
      check("strobes_a3", strobe_cnt, 32'd3);
      check("rx_data_a3", {24'b0, rx_data_o}, 32'hA3);
      check_read("status_a3", 5'd3, 32'h2);
      cfg_write(5'd3, 32'h2);
      check_read("status_w1c", 5'd3, 32'h0);

      // DIV=0 acts as 1; CMD=3 picks TX_DATA; RX disabled ignores the line
      cfg_write(5'd0, 32'h0000_0001);
      cfg_write(5'd1, 32'h3);
      tx_frame_check("div0", {1'b1, 8'h55, 1'b0}, 1, 0);
      check_read("div0_idle", 5'd3, 32'h0);
      check("strobes_rx_off", strobe_cnt, 32'd3);

      // Directly driven RX: good frame, then stop bit low
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      cfg_write(5'd0, 32'h000A_0003);
      wait_cyc(5);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      wait_cyc(10);
      check("strobes_3c", strobe_cnt, 32'd4);
      check("rx_data_3c", {24'b0, rx_data_o}, 32'h3C);
      send_frame(8'h99, 1'b0, 1'b0, 1'b0);
      wait_cyc(20);
      check_read("frame_err", 5'd3, 32'h6);
      check("rx_data_hold", {24'b0, rx_data_o}, 32'h3C);
      check("strobes_ferr", strobe_cnt, 32'd4);
      cfg_write(5'd3, 32'hE);
      check_read("status_clr_all", 5'd3, 32'h0);

      // 3-cycle low glitch is rejected
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      wait_cyc(30);
      check("strobes_glitch", strobe_cnt, 32'd4);
      check_read("status_glitch", 5'd3, 32'h0);

`ifdef UART_PARITY_EN
      cfg_write(5'd0, 32'h000A_0007);
      check_read("ctrl_par_rb", 5'd0, 32'h000A_0007);
      loop_en = 1'b1;
      cfg_write(5'd1, 32'h1);
      wait_cyc(120);
      check("strobes_par_ok", strobe_cnt, 32'd5);
      check("last_rx_par_ok", {24'b0, last_rx}, 32'h55);
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      wait_cyc(10);
      check_read("parity_err", 5'd3, 32'hA);
      check("strobes_par_bad", strobe_cnt, 32'd5);
      cfg_write(5'd3, 32'hE);
      check_read("status_clr_par", 5'd3, 32'h0);
`endif

      // Reset in the middle of a transmission
      loop_en = 1'b1;
      cfg_write(5'd0, 32'h000A_0003);
      cfg_write(5'd1, 32'h1);
      wait_cyc(30);
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      check("rst_mid_tx_o", {31'b0, tx_o}, 32'd1);
      check("rst_mid_rx_data", {24'b0, rx_data_o}, 32'h0);
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      wait_cyc(1);
      check("rst_mid_tx_o_after", {31'b0, tx_o}, 32'd1);
      check_read("rst_mid_status", 5'd3, 32'h0);
      check_read("rst_mid_ctrl", 5'd0, 32'h28B0_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
